// File: rtl/alu_ctrl.sv
// ALU sequencing controller: owns a 16x16 register file and the status flags,
// and steps each accepted operation through READ, EXEC and WRITE on an external ALU.
module alu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_code,
    input  logic [3:0]  op_rdest,
    input  logic [3:0]  op_rsrc,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  psr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
    typedef enum logic [1:0] {CLS_NOP, CLS_WRITE, CLS_CMP} op_class_t;

    function automatic op_class_t classify(input logic [7:0] op);
        op_class_t cls;
        if (((op >= 8'h01) && (op <= 8'h09)) || (op == 8'h0D) ||
            ((op >= 8'h50) && (op <= 8'h80)) || (op == 8'h84) ||
            ((op >= 8'h88) && (op <= 8'h8B))) begin
            cls = CLS_WRITE;
        end else if ((op == 8'h0B) || (op == 8'h0F)) begin
            cls = CLS_CMP;
        end else begin
            cls = CLS_NOP;
        end
        return cls;
    endfunction

    state_t        r_state;
    logic          r_op_ready;
    logic          r_done;
    logic [7:0]    r_op_code;
    logic [3:0]    r_rdest;
    logic [3:0]    r_rsrc;
    logic [15:0]   r_regs [16];
    logic [4:0]    r_psr;
    logic [4:0]    r_cap_flags;
    logic [15:0]   r_result;
    logic [15:0]   r_alu_a;
    logic [15:0]   r_alu_b;
    logic [7:0]    r_alu_opcode;
    logic          r_alu_cin;
    op_class_t     w_class;

    assign w_class = classify(r_op_code);

    // Operation sequencer: the ALU operand registers double as the READ-stage
    // operand latches, so they are only non-zero while in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op_ready   <= 1'b1;
            r_done       <= 1'b0;
            r_op_code    <= 8'h00;
            r_rdest      <= 4'h0;
            r_rsrc       <= 4'h0;
            r_psr        <= 5'b00000;
            r_cap_flags  <= 5'b00000;
            r_result     <= 16'h0000;
            r_alu_a      <= 16'h0000;
            r_alu_b      <= 16'h0000;
            r_alu_opcode <= 8'h00;
            r_alu_cin    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_op_code  <= op_code;
                        r_rdest    <= op_rdest;
                        r_rsrc     <= op_rsrc;
                        r_op_ready <= 1'b0;
                        r_state    <= S_READ;
                    end else begin
                        r_op_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_alu_a      <= r_regs[r_rdest];
                    r_alu_b      <= r_regs[r_rsrc];
                    r_alu_opcode <= r_op_code;
                    r_alu_cin    <= r_psr[3];
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    // result carries the write value; compares and NOPs report zero
                    r_result     <= (w_class == CLS_WRITE) ? alu_c : 16'h0000;
                    r_cap_flags  <= alu_flags;
                    r_done       <= 1'b1;
                    r_alu_a      <= 16'h0000;
                    r_alu_b      <= 16'h0000;
                    r_alu_opcode <= 8'h00;
                    r_alu_cin    <= 1'b0;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_class == CLS_WRITE) begin
                        r_regs[r_rdest] <= r_result;
                    end
                    if (w_class != CLS_NOP) begin
                        r_psr <= r_cap_flags;
                    end
                    r_done     <= 1'b0;
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready   = r_op_ready;
    assign done       = r_done;
    assign result     = r_result;
    assign psr        = r_psr;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign alu_cin    = r_alu_cin;
    assign dbg_data   = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU drives alu_c/alu_flags, and an
// operation-level model of the register file and flags predicts every output.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_code;
    logic [3:0]  op_rdest;
    logic [3:0]  op_rsrc;
    logic        done;
    logic [15:0] result;
    logic [4:0]  psr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_opcode;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;
    logic [15:0] m_result;

    alu_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rdest(op_rdest), .op_rsrc(op_rsrc),
        .done(done), .result(result), .psr(psr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Flags {Z,C,O,N,L}; L is a signed less-than produced only by compares.
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic cf, of, lf;
        s = 17'd0; cf = 1'b0; of = 1'b0; lf = 1'b0;
        if (op == 8'h05 || op == 8'h06 || op == 8'h07) begin
            s  = {1'b0, a} + {1'b0, b} + {16'd0, (op == 8'h07) ? cin : 1'b0};
            c  = s[15:0];
            cf = s[16];
            of = (a[15] == b[15]) && (c[15] != a[15]);
        end else if (op == 8'h0B || op == 8'h0F) begin
            s  = {1'b0, a} - {1'b0, b};
            c  = s[15:0];
            cf = s[16];
            of = (a[15] != b[15]) && (c[15] != a[15]);
            lf = $signed(a) < $signed(b);
        end else if (op == 8'h08) begin
            c = ~a;
        end else if (op >= 8'h50 && op <= 8'h7F) begin
            s  = {1'b0, a} + {13'd0, op[3:0]};
            c  = s[15:0];
            cf = s[16];
        end else begin
            c = a ^ {b[7:0], b[15:8]} ^ {8'h00, op};
        end
        return {(c == 16'h0000), cf, of, c[15], lf, c};
    endfunction

    always_comb begin
        {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);
    end

    function automatic bit is_write(input logic [7:0] op);
        return op inside {[8'h01:8'h09], 8'h0D, [8'h50:8'h80], 8'h84, [8'h88:8'h8B]};
    endfunction

    function automatic bit is_cmp(input logic [7:0] op);
        return op inside {8'h0B, 8'h0F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input logic [3:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("R%0d", idx), dbg_data, exp);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+2 of the next IDLE cycle.
    task automatic run_op(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input bit hold);
        logic [15:0] ea, eb, ec;
        logic [4:0]  ef;
        logic        ecin;
        logic [4:0]  old_psr;
        ea = m_regs[rd]; eb = m_regs[rs]; ecin = m_psr[3]; old_psr = m_psr;
        {ef, ec} = alu_fn(op, ea, eb, ecin);
        check("ready_idle", op_ready, 1'b1);
        op_valid = 1'b1; op_code = op; op_rdest = rd; op_rsrc = rs;
        @(posedge clk); #1;
        op_valid = hold; op_code = 8'($urandom); op_rdest = 4'($urandom); op_rsrc = 4'($urandom);
        check("ready_read", op_ready, 1'b0);
        check("done_read", done, 1'b0);
        check("alu_a_read", alu_a, 16'h0000);
        @(posedge clk); #1;
        op_code = 8'($urandom); op_rdest = 4'($urandom);
        check("ready_exec", op_ready, 1'b0);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_opcode", alu_opcode, op);
        check("alu_cin", alu_cin, ecin);
        @(posedge clk); #1;
        m_result = is_write(op) ? ec : 16'h0000;
        check("done_write", done, 1'b1);
        check("ready_write", op_ready, 1'b0);
        check("result", result, m_result);
        check("psr_precommit", psr, old_psr);
        check("alu_opcode_write", alu_opcode, 8'h00);
        @(posedge clk); #1;
        if (is_write(op)) m_regs[rd] = ec;
        if (is_write(op) || is_cmp(op)) m_psr = ef;
        check("done_idle", done, 1'b0);
        check("psr", psr, m_psr);
        check("result_held", result, m_result);
        check_reg(rd, m_regs[rd]);
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rop;
        reset = 1'b1; op_valid = 1'b0; op_code = 8'h00; op_rdest = 4'h0; op_rsrc = 4'h0;
        dbg_addr = 4'h0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_psr = 5'b00000; m_result = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", op_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_psr", psr, 5'b00000);
        check("rst_result", result, 16'h0000);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_opcode", alu_opcode, 8'h00);
        for (int i = 0; i < 16; i++) check_reg(4'(i), 16'h0000);

        // Preload via immediate adds, then a register-register add.
        run_op(8'h53, 4'd1, 4'd0, 1'b0);
        run_op(8'h54, 4'd2, 4'd0, 1'b0);
        run_op(8'h05, 4'd1, 4'd2, 1'b0);
        check_reg(4'd1, 16'h0007);
        check("add_psr", psr, 5'b00000);

        // Carry out of ADDU feeds alu_cin of the following ADDC.
        run_op(8'h08, 4'd3, 4'd0, 1'b0);
        check_reg(4'd3, 16'hFFFF);
        run_op(8'h51, 4'd4, 4'd0, 1'b0);
        run_op(8'h06, 4'd3, 4'd4, 1'b0);
        check("addu_psr", psr, 5'b11000);
        check_reg(4'd3, 16'h0000);
        run_op(8'h07, 4'd5, 4'd6, 1'b0);
        check_reg(4'd5, 16'h0001);

        // NOP and unclassified opcodes leave C-only psr and registers alone.
        run_op(8'h52, 4'd10, 4'd0, 1'b0);
        run_op(8'h08, 4'd11, 4'd0, 1'b0);
        run_op(8'h05, 4'd11, 4'd10, 1'b0);
        check("carry_psr", psr, 5'b01000);
        run_op(8'h00, 4'd11, 4'd10, 1'b0);
        run_op(8'h0A, 4'd11, 4'd10, 1'b0);
        check("nop_psr", psr, 5'b01000);
        check("nop_result", result, 16'h0000);
        check_reg(4'd11, 16'h0001);

        // Compare: flags only.
        run_op(8'h51, 4'd7, 4'd0, 1'b0);
        run_op(8'h08, 4'd7, 4'd0, 1'b0);
        run_op(8'h51, 4'd8, 4'd0, 1'b0);
        run_op(8'h0B, 4'd7, 4'd8, 1'b0);
        check("cmp_psr", psr, 5'b00011);
        check("cmp_result", result, 16'h0000);
        check_reg(4'd7, 16'hFFFE);

        // op_valid held high across back-to-back operations.
        run_op(8'h05, 4'd12, 4'd1, 1'b1);
        run_op(8'h57, 4'd12, 4'd12, 1'b1);
        run_op(8'h06, 4'd13, 4'd12, 1'b1);

        // Randomised operations across all opcode classes.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: rop = 8'($urandom_range(8'h50, 8'h7F));
                1: rop = 8'($urandom_range(8'h05, 8'h08));
                2: rop = ($urandom_range(0, 1) == 0) ? 8'h0B : 8'h0F;
                3: rop = 8'($urandom_range(8'h80, 8'h8B));
                default: rop = 8'($urandom);
            endcase
            run_op(rop, 4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Reset during EXEC aborts without commit.
        if (m_regs[1] == 16'h0000) run_op(8'h08, 4'd1, 4'd1, 1'b0);
        run_op(8'h0F, 4'd1, 4'd1, 1'b0);
        check("self_cmp_psr", psr, 5'b10000);
        op_valid = 1'b1; op_code = 8'h05; op_rdest = 4'd1; op_rsrc = 4'd2;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_exec_opcode", alu_opcode, 8'h05);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_psr = 5'b00000; m_result = 16'h0000;
        check("abort_done", done, 1'b0);
        check("abort_alu_a", alu_a, 16'h0000);
        check("abort_alu_opcode", alu_opcode, 8'h00);
        check("abort_psr", psr, 5'b00000);
        check("abort_result", result, 16'h0000);
        check_reg(4'd1, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", op_ready, 1'b1);
        check("post_rst_done", done, 1'b0);
        run_op(8'h53, 4'd1, 4'd0, 1'b0);
        check_reg(4'd1, 16'h0003);

        for (int i = 0; i < 16; i++) check_reg(4'(i), m_regs[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 op_valid  input  1  requester has an operation on op_* inputs.
REQ-004 op_ready  output  1  controller can accept an operation this cycle.
REQ-005 op_code  input  8  ALU opcode, passed unchanged to ALU; immediate forms carry immediate in low bits.
REQ-006 op_rdest  input  4  destination register index, also source of ALU operand A.
REQ-007 op_rsrc  input  4  register index for ALU operand B.
REQ-008 done  output  1  one-cycle pulse: operation committed.
REQ-009 result  output  16  value written (or that would be written) by the completed operation; held until next done.
REQ-010 psr  output  5  processor status flags {Z,C,O,N,L}, bit 4..0.
REQ-011 alu_a, alu_b  output  16 each  ALU operands.
REQ-012 alu_opcode  output  8  ALU opcode.
REQ-013 alu_cin  output  1  ALU carry in.
REQ-014 alu_c  input  16  ALU result (combinational from alu_* outputs).
REQ-015 alu_flags  input  5  ALU flags {Z,C,O,N,L}.
REQ-016 dbg_addr  input  4 / dbg_data  output  16  combinational read port of register file.

Function
REQ-017 Block SHALL contain a 16 x 16-bit register file R0..R15, all writable, one write port, read by index.
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WRITE; sequence IDLE->READ->EXEC->WRITE->IDLE, no other transitions except reset.
REQ-019 op_ready SHALL be 1 only in IDLE; accept occurs on edge where op_valid=1 and op_ready=1; IDLE with op_valid=0 stays IDLE.
REQ-020 On accept, op_code, op_rdest, op_rsrc SHALL be latched; later changes on op_* inputs are ignored until next accept.
REQ-021 READ: operand regs SHALL latch A=R[rdest], B=R[rsrc] (values as of end of READ, after any prior commit).
REQ-022 EXEC: alu_a=A, alu_b=B, alu_opcode=latched op_code, alu_cin=psr[3]; alu_c and alu_flags captured at end of EXEC; outside EXEC alu_a/alu_b/alu_opcode/alu_cin SHALL be 0.
REQ-023 WRITE: done=1 for exactly this cycle; result shows captured alu_c; commits occur on the edge leaving WRITE.
REQ-024 Latency: accept edge E0, done high in cycle after E2, commit at E3; op_ready returns 1 after E3; max throughput one op per 4 cycles.
REQ-025 Write class (register write and psr update): opcodes 0x01-0x09, 0x0D, 0x50-0x7F, 0x80, 0x84, 0x88, 0x89, 0x8A, 0x8B.
REQ-026 Compare class (psr update only, no register write): 0x0B, 0x0F.
REQ-027 All other opcodes SHALL be NOP: full 4-cycle sequence and done pulse, no register write, psr unchanged, result=0.
REQ-028 Register write SHALL store captured alu_c to R[rdest]; psr SHALL load captured alu_flags; any X bits in alu_flags for committed classes are a verification failure.
REQ-029 rdest=rsrc SHALL be legal; both operands read same register.
REQ-030 dbg_data SHALL reflect a write in the cycle after the commit edge.

Reset
REQ-031 reset=1 SHALL force state IDLE, R0..R15=0, psr=0, result=0, done=0, latched op=0, alu_* outputs=0, regardless of state; reset mid-operation aborts with no commit.
REQ-032 First cycle after reset deasserts SHALL have op_ready=1.

Verification
REQ-033 Preload R1=0x0003, R2=0x0004 (via ADD from zeros impossible; use ADDI 0x53/0x54 onto R1/R2), then ADD 0x05 rdest=1 rsrc=2 -> done 3 cycles after accept, R1=0x0007, psr=00000.
REQ-034 R3=0xFFFF, R4=0x0001, ADDU 0x06 then ADDC 0x07 on R5=0,R6=0 -> first psr[3]=1, R3=0x0000, Z=1; ADDC result R5=0x0001 (alu_cin=1).
REQ-035 CMP 0x0B rdest=R7=0xFFFE, rsrc=R8=0x0001 -> psr=00011, R7 unchanged, result=0.
REQ-036 NOP 0x00 and unclassified 0x0A after psr=01000 -> done pulses, psr stays 01000, no register changes.
REQ-037 op_valid held high for 3 back-to-back ops -> accepts spaced exactly 4 cycles, op_ready low in READ/EXEC/WRITE, input changes mid-op ignored.
REQ-038 reset asserted during EXEC of ADD to R1 -> next cycle IDLE, R1=0, psr=0, no done pulse.
